// File: rtl/sccomp_pkg.sv
// sccomp_pkg: shared definitions for the single-cycle RV32I-subset computer.
// Contents: major opcode constants, ALU operation enum, immediate format enum,
// write-back source enum and the immediate generator.
`timescale 1ns/1ps
package sccomp_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB
  } alu_op_e;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_type_e;

  typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4} wb_sel_e;

  // Sign-extended immediate for each RV32I instruction format.
  function automatic logic [31:0] imm_gen(input logic [31:0] ins, input imm_type_e t);
    logic [31:0] r;
    case (t)
      IMM_S:   r = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      IMM_B:   r = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      IMM_U:   r = {ins[31:12], 12'b0};
      IMM_J:   r = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default: r = {{20{ins[31]}}, ins[31:20]};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sccomp_im.sv
// im: instruction ROM of 2^IM_AW 32-bit words, read combinationally.
// The array ROM is preloaded from outside through the hierarchy (U_IM.ROM).
// Ports: addr  - word address (byte PC bits [IM_AW+1:2])
//        instr - instruction word at addr
`timescale 1ns/1ps
module im
  import sccomp_pkg::*;
#(
  parameter int IM_AW = 7
) (
  input  logic [IM_AW-1:0] addr,
  output logic [31:0]      instr
);

  logic [31:0] ROM [0:2**IM_AW-1];

  assign instr = ROM[addr];

endmodule

// File: rtl/sccomp.sv
// sccomp: single-cycle RV32I-subset computer. One instruction retires per
// rising clock edge: fetch, decode, register read, ALU, data RAM read and
// write-back are all combinational; PC, register file and the store commit
// on the edge.
// Ports: clk      - system clock
//        rstn     - asynchronous active-low reset (PC=RESET_PC, x1..x31=0)
//        reg_sel  - debug register index
//        reg_data - combinational contents of x[reg_sel] (0 for x0)
`timescale 1ns/1ps
module sccomp
  import sccomp_pkg::*;
#(
  parameter int          IM_AW    = 7,
  parameter int          DM_AW    = 7,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [4:0]  reg_sel,
  output logic [31:0] reg_data
);

  logic [31:0] PC;
  logic [31:0] instr;
  logic [31:0] rf   [0:31];
  logic [31:0] dmem [0:2**DM_AW-1];

  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] rs1_val, rs2_val, imm, alu_a, alu_b, alu_res;
  logic [31:0] mem_rdata, wb_data, pc_plus4, pc_next;
  logic signed [31:0] rs1_s, rs2_s;
  logic        reg_we, mem_we, is_branch, is_jal, is_jalr;
  logic        src_a_pc, src_b_imm, br_taken;
  alu_op_e     alu_op;
  imm_type_e   imm_type;
  wb_sel_e     wb_sel;

  function automatic logic [31:0] alu(input alu_op_e op, input logic [31:0] a,
                                      input logic [31:0] b);
    logic signed [31:0] a_s, b_s;
    logic [31:0] r;
    a_s = a;
    b_s = b;
    case (op)
      ALU_SUB:   r = a - b;
      ALU_SLL:   r = a << b[4:0];
      ALU_SLT:   r = {31'd0, a_s < b_s};
      ALU_SLTU:  r = {31'd0, a < b};
      ALU_XOR:   r = a ^ b;
      ALU_SRL:   r = a >> b[4:0];
      ALU_SRA:   r = a_s >>> b[4:0];
      ALU_OR:    r = a | b;
      ALU_AND:   r = a & b;
      ALU_PASSB: r = b;
      default:   r = a + b;
    endcase
    return r;
  endfunction

  // ---- fetch
  im #(.IM_AW(IM_AW)) U_IM (
    .addr  (PC[IM_AW+1:2]),
    .instr (instr)
  );

  // ---- decode / register read
  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];

  assign rs1_val = (rs1 == 5'd0) ? 32'd0 : rf[rs1];
  assign rs2_val = (rs2 == 5'd0) ? 32'd0 : rf[rs2];

  // Anything not recognised leaves every enable low, which is a NOP.
  always_comb begin
    reg_we    = 1'b0;
    mem_we    = 1'b0;
    is_branch = 1'b0;
    is_jal    = 1'b0;
    is_jalr   = 1'b0;
    src_a_pc  = 1'b0;
    src_b_imm = 1'b0;
    alu_op    = ALU_ADD;
    imm_type  = IMM_I;
    wb_sel    = WB_ALU;
    case (opcode)
      OP_LUI: begin
        reg_we = 1'b1; src_b_imm = 1'b1; imm_type = IMM_U; alu_op = ALU_PASSB;
      end
      OP_AUIPC: begin
        reg_we = 1'b1; src_a_pc = 1'b1; src_b_imm = 1'b1; imm_type = IMM_U;
      end
      OP_JAL: begin
        reg_we = 1'b1; is_jal = 1'b1; imm_type = IMM_J; wb_sel = WB_PC4;
      end
      OP_JALR: if (funct3 == 3'd0) begin
        reg_we = 1'b1; is_jalr = 1'b1; src_b_imm = 1'b1; wb_sel = WB_PC4;
      end
      OP_BRANCH: begin
        is_branch = 1'b1; imm_type = IMM_B;
      end
      OP_LOAD: if (funct3 == 3'd2) begin
        reg_we = 1'b1; src_b_imm = 1'b1; wb_sel = WB_MEM;
      end
      OP_STORE: if (funct3 == 3'd2) begin
        mem_we = 1'b1; src_b_imm = 1'b1; imm_type = IMM_S;
      end
      OP_I: begin
        reg_we    = 1'b1;
        src_b_imm = 1'b1;
        case (funct3)
          3'd1: begin alu_op = ALU_SLL; reg_we = (funct7 == 7'h00); end
          3'd2: alu_op = ALU_SLT;
          3'd3: alu_op = ALU_SLTU;
          3'd4: alu_op = ALU_XOR;
          3'd5: begin
            alu_op = funct7[5] ? ALU_SRA : ALU_SRL;
            reg_we = (funct7 == 7'h00) || (funct7 == 7'h20);
          end
          3'd6: alu_op = ALU_OR;
          3'd7: alu_op = ALU_AND;
          default: alu_op = ALU_ADD;
        endcase
      end
      OP_R: begin
        reg_we = 1'b1;
        if (funct7 == 7'h00) begin
          case (funct3)
            3'd1:    alu_op = ALU_SLL;
            3'd2:    alu_op = ALU_SLT;
            3'd3:    alu_op = ALU_SLTU;
            3'd4:    alu_op = ALU_XOR;
            3'd5:    alu_op = ALU_SRL;
            3'd6:    alu_op = ALU_OR;
            3'd7:    alu_op = ALU_AND;
            default: alu_op = ALU_ADD;
          endcase
        end else if (funct7 == 7'h20 && funct3 == 3'd0) begin
          alu_op = ALU_SUB;
        end else if (funct7 == 7'h20 && funct3 == 3'd5) begin
          alu_op = ALU_SRA;
        end else begin
          reg_we = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // ---- execute
  assign imm     = imm_gen(instr, imm_type);
  assign alu_a   = src_a_pc  ? PC  : rs1_val;
  assign alu_b   = src_b_imm ? imm : rs2_val;
  assign alu_res = alu(alu_op, alu_a, alu_b);

  assign rs1_s = rs1_val;
  assign rs2_s = rs2_val;

  always_comb begin
    case (funct3)
      3'd0:    br_taken = (rs1_val == rs2_val);
      3'd1:    br_taken = (rs1_val != rs2_val);
      3'd4:    br_taken = (rs1_s <  rs2_s);
      3'd5:    br_taken = (rs1_s >= rs2_s);
      3'd6:    br_taken = (rs1_val <  rs2_val);
      3'd7:    br_taken = (rs1_val >= rs2_val);
      default: br_taken = 1'b0;
    endcase
  end

  // ---- memory / write-back select
  assign mem_rdata = dmem[alu_res[DM_AW+1:2]];
  assign pc_plus4  = PC + 32'd4;

  always_comb begin
    case (wb_sel)
      WB_MEM:  wb_data = mem_rdata;
      WB_PC4:  wb_data = pc_plus4;
      default: wb_data = alu_res;
    endcase
  end

  always_comb begin
    if (is_jal || (is_branch && br_taken)) pc_next = PC + imm;
    else if (is_jalr)                      pc_next = alu_res & ~32'd1;
    else                                   pc_next = pc_plus4;
  end

  // ---- commit
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      PC <= RESET_PC;
      for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
    end else begin
      PC <= pc_next;
      if (reg_we && rd != 5'd0) rf[rd] <= wb_data;
    end
  end

  // Data RAM keeps its contents over reset; stores are suppressed while held.
  always_ff @(posedge clk) begin
    if (mem_we && rstn) dmem[alu_res[DM_AW+1:2]] <= rs2_val;
  end

  assign reg_data = (reg_sel == 5'd0) ? 32'd0 : rf[reg_sel];

endmodule

// File: tb/tb_sccomp.sv
// tb_sccomp: directed programs plus random instruction streams, each run in
// lockstep with an instruction-level reference model of the RV32I subset.
`timescale 1ns/1ps
module tb_sccomp;
  import sccomp_pkg::*;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic [4:0]  reg_sel = 5'd0;
  logic [31:0] reg_data;

  sccomp #(.IM_AW(7), .DM_AW(7), .RESET_PC(32'h0)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .reg_sel  (reg_sel),
    .reg_data (reg_data)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] rom_m [128];
  logic [31:0] x_m   [32];
  logic [31:0] mem_m [128];
  logic [31:0] pc_m;
  logic [31:0] prog  [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- instruction encoders
  function automatic logic [31:0] enc_i(input logic [6:0] op, input int f3, input int rd,
                                        input int rs1, input int imm);
    logic [31:0] im;
    im = imm;
    return {im[11:0], rs1[4:0], f3[2:0], rd[4:0], op};
  endfunction

  function automatic logic [31:0] enc_r(input int f7, input int f3, input int rd,
                                        input int rs1, input int rs2);
    return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], OP_R};
  endfunction

  function automatic logic [31:0] enc_s(input int rs1, input int rs2, input int imm);
    logic [31:0] im;
    im = imm;
    return {im[11:5], rs2[4:0], rs1[4:0], 3'd2, im[4:0], OP_STORE};
  endfunction

  function automatic logic [31:0] enc_b(input int f3, input int rs1, input int rs2, input int imm);
    logic [31:0] im;
    im = imm;
    return {im[12], im[10:5], rs2[4:0], rs1[4:0], f3[2:0], im[4:1], im[11], OP_BRANCH};
  endfunction

  function automatic logic [31:0] enc_u(input logic [6:0] op, input int rd, input int imm);
    logic [31:0] im;
    im = imm;
    return {im[19:0], rd[4:0], op};
  endfunction

  function automatic logic [31:0] enc_j(input int rd, input int imm);
    logic [31:0] im;
    im = imm;
    return {im[20], im[10:1], im[11], im[19:12], rd[4:0], OP_JAL};
  endfunction

  // ---------------- reference model (architectural, one instruction per call)
  function automatic bit arith(input logic [2:0] f3, input logic [6:0] f7, input bit rtype,
                               input logic [31:0] a, input logic [31:0] b,
                               output logic [31:0] r);
    bit alt, ok;
    alt = (f7 == 7'h20);
    if (rtype) ok = (f7 == 7'h00) || (alt && (f3 == 3'd0 || f3 == 3'd5));
    else       ok = (f3 != 3'd1 && f3 != 3'd5) || (f7 == 7'h00) || (f3 == 3'd5 && alt);
    case (f3)
      3'd0: r = (rtype && alt) ? a - b : a + b;
      3'd1: r = a << b[4:0];
      3'd2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: r = (a < b) ? 32'd1 : 32'd0;
      3'd4: r = a ^ b;
      3'd5: if (alt) r = $signed(a) >>> b[4:0]; else r = a >> b[4:0];
      3'd6: r = a | b;
      default: r = a & b;
    endcase
    return ok;
  endfunction

  task automatic model_reset();
    pc_m = 32'd0;
    for (int i = 0; i < 32; i++) x_m[i] = 32'd0;
  endtask

  task automatic step();
    logic [31:0] ins, a, b, ii, is, ib, iu, ij, val, nxt;
    logic [6:0]  op, f7;
    logic [2:0]  f3;
    logic [4:0]  rd;
    bit          wr, t;
    ins = rom_m[(pc_m >> 2) % 128];
    op = ins[6:0]; rd = ins[11:7]; f3 = ins[14:12]; f7 = ins[31:25];
    a  = x_m[ins[19:15]];
    b  = x_m[ins[24:20]];
    ii = $signed(ins) >>> 20;
    is = $signed({ins[31:25], ins[11:7], 20'b0}) >>> 20;
    ib = $signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0, 19'b0}) >>> 19;
    iu = {ins[31:12], 12'b0};
    ij = $signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0, 11'b0}) >>> 11;
    nxt = pc_m + 32'd4;
    wr = 1'b0; val = 32'd0; t = 1'b0;
    case (op)
      7'b0110111: begin wr = 1'b1; val = iu; end
      7'b0010111: begin wr = 1'b1; val = pc_m + iu; end
      7'b1101111: begin wr = 1'b1; val = pc_m + 32'd4; nxt = pc_m + ij; end
      7'b1100111: if (f3 == 3'd0) begin
        wr = 1'b1; val = pc_m + 32'd4; nxt = (a + ii) & 32'hFFFF_FFFE;
      end
      7'b1100011: begin
        case (f3)
          3'd0: t = (a == b);
          3'd1: t = (a != b);
          3'd4: t = ($signed(a) <  $signed(b));
          3'd5: t = ($signed(a) >= $signed(b));
          3'd6: t = (a <  b);
          3'd7: t = (a >= b);
          default: t = 1'b0;
        endcase
        if (t) nxt = pc_m + ib;
      end
      7'b0000011: if (f3 == 3'd2) begin wr = 1'b1; val = mem_m[((a + ii) >> 2) % 128]; end
      7'b0100011: if (f3 == 3'd2) mem_m[((a + is) >> 2) % 128] = b;
      7'b0010011: wr = arith(f3, f7, 1'b0, a, ii, val);
      7'b0110011: wr = arith(f3, f7, 1'b1, a, b, val);
      default: ;
    endcase
    if (wr && rd != 5'd0) x_m[rd] = val;
    pc_m = nxt;
  endtask

  // ---------------- bench helpers
  task automatic load_prog(input logic [31:0] p[$]);
    for (int i = 0; i < 128; i++) begin
      rom_m[i] = (i < p.size()) ? p[i] : 32'd0;
      dut.U_IM.ROM[i] = rom_m[i];
    end
  endtask

  task automatic chk_reg(input string tag, input int r, input logic [31:0] exp);
    reg_sel = 5'(r);
    #0.05;
    check(tag, reg_data, exp);
  endtask

  // Asserts reset between edges, swaps in a program, releases on a falling edge.
  task automatic start_prog(input logic [31:0] p[$]);
    rstn = 1'b0;
    model_reset();
    #1;
    check("rst_pc", dut.PC, 32'd0);
    #19;
    load_prog(p);
    check("rst_pc_held", dut.PC, 32'd0);
    for (int r = 0; r < 32; r++) chk_reg($sformatf("rst_x%0d", r), r, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic cycle(input bit all);
    check("pc", dut.PC, pc_m);
    if (all) begin
      for (int r = 0; r < 32; r++) chk_reg($sformatf("x%0d", r), r, x_m[r]);
    end else begin
      int r;
      r = $urandom_range(0, 31);
      chk_reg($sformatf("x%0d", r), r, x_m[r]);
    end
    @(posedge clk);
    step();
    @(negedge clk);
  endtask

  task automatic mid_reset();
    @(posedge clk);
    step();
    #2;
    rstn = 1'b0;
    #1;
    check("async_rst_pc", dut.PC, 32'd0);
    for (int r = 1; r < 4; r++) chk_reg($sformatf("async_rst_x%0d", r), r, 32'd0);
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
  endtask

  function automatic int rreg();
    return ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 7));
  endfunction

  function automatic logic [31:0] rand_ins();
    int k, rd, a, b, f3, imm, f7;
    int bt[6] = '{0, 1, 4, 5, 6, 7};
    k  = $urandom_range(0, 15);
    rd = rreg(); a = rreg(); b = rreg();
    f3 = $urandom_range(0, 7);
    imm = $urandom_range(0, 4095);
    case (k)
      0:  return enc_u(OP_LUI, rd, $urandom);
      1:  return enc_u(OP_AUIPC, rd, $urandom);
      2:  return enc_j(rd, int'($urandom_range(0, 32)) * 4 - 64);
      3:  return enc_i(OP_JALR, 0, rd, a, imm);
      4:  return enc_b(bt[$urandom_range(0, 5)], a, b, int'($urandom_range(0, 32)) * 4 - 64);
      5:  return enc_i(OP_LOAD, 2, rd, a, imm);
      6:  return enc_s(a, b, imm);
      7, 8, 9: begin
        if ((f3 == 1 || f3 == 5) && $urandom_range(0, 7) != 0)
          imm = (f3 == 5 && $urandom_range(0, 1) == 1 ? 32'h400 : 0) + int'($urandom_range(0, 31));
        return enc_i(OP_I, f3, rd, a, imm);
      end
      10, 11, 12: begin
        k  = $urandom_range(0, 9);
        f7 = (k < 6) ? 0 : (k < 9) ? 32 : int'($urandom_range(0, 127));
        return enc_r(f7, f3, rd, a, b);
      end
      13: return $urandom;
      14: return 32'd0;
      default: return enc_i(OP_I, 0, rd, a, imm);
    endcase
  endfunction

  // ---------------- test sequence
  initial begin
    logic [31:0] rs;
    #1;

    // ALU, x0, branches, jal, store/load
    prog = {};
    prog.push_back(enc_i(OP_I, 0, 1, 0, 5));        // 0  addi x1,x0,5
    prog.push_back(enc_i(OP_I, 0, 2, 0, -3));       // 4  addi x2,x0,-3
    prog.push_back(enc_r(0, 0, 3, 1, 2));           // 8  add  x3,x1,x2
    prog.push_back(enc_r(32, 0, 4, 1, 2));          // 12 sub  x4,x1,x2
    prog.push_back(enc_r(0, 2, 5, 2, 1));           // 16 slt  x5,x2,x1
    prog.push_back(enc_i(OP_I, 0, 0, 1, 7));        // 20 addi x0,x1,7
    prog.push_back(enc_b(4, 2, 1, 8));              // 24 blt  x2,x1,+8 (taken)
    prog.push_back(enc_i(OP_I, 0, 8, 0, 99));       // 28 skipped
    prog.push_back(enc_b(6, 2, 1, 8));              // 32 bltu x2,x1,+8 (not taken)
    prog.push_back(enc_i(OP_I, 0, 9, 0, 42));       // 36 addi x9,x0,42
    prog.push_back(enc_b(1, 1, 0, 8));              // 40 bne  x1,x0,+8
    prog.push_back(enc_i(OP_I, 0, 10, 0, 77));      // 44 skipped
    prog.push_back(enc_j(7, 12));                   // 48 jal  x7,+12
    prog.push_back(enc_i(OP_I, 0, 11, 0, 1));       // 52 skipped
    prog.push_back(enc_i(OP_I, 0, 11, 0, 2));       // 56 skipped
    prog.push_back(enc_i(OP_I, 0, 1, 0, 32'h55));   // 60 addi x1,x0,0x55
    prog.push_back(enc_s(0, 1, 8));                 // 64 sw   x1,8(x0)
    prog.push_back(enc_i(OP_LOAD, 2, 6, 0, 8));     // 68 lw   x6,8(x0)
    prog.push_back(enc_j(0, 0));                    // 72 jal  x0,0
    start_prog(prog);
    cycle(1'b1);
    check("pc_first_edge", dut.PC, 32'd4);
    repeat (19) cycle(1'b1);
    check("a_pc_halt", dut.PC, 32'd72);
    chk_reg("a_add", 3, 32'd2);
    chk_reg("a_sub", 4, 32'd8);
    chk_reg("a_slt", 5, 32'd1);
    chk_reg("a_x0", 0, 32'd0);
    chk_reg("a_blt_skip", 8, 32'd0);
    chk_reg("a_bltu_fall", 9, 32'd42);
    chk_reg("a_bne_skip", 10, 32'd0);
    chk_reg("a_jal_link", 7, 32'd52);
    chk_reg("a_jal_skip", 11, 32'd0);
    chk_reg("a_lw", 6, 32'h55);

    // Clear the whole data RAM so later random loads have known contents
    prog = {};
    prog.push_back(enc_i(OP_I, 0, 1, 0, 0));        // 0  addi x1,x0,0
    prog.push_back(enc_i(OP_I, 0, 2, 0, 512));      // 4  addi x2,x0,512
    prog.push_back(enc_s(1, 0, 0));                 // 8  sw   x0,0(x1)
    prog.push_back(enc_i(OP_I, 0, 1, 1, 4));        // 12 addi x1,x1,4
    prog.push_back(enc_b(4, 1, 2, -8));             // 16 blt  x1,x2,-8
    prog.push_back(enc_j(0, 0));                    // 20 halt
    start_prog(prog);
    repeat (400) cycle(1'b0);
    check("clr_pc_halt", dut.PC, 32'd20);

    // Bubble sort of {3,1,4,2} at byte addresses 0..12
    prog = {};
    prog.push_back(enc_i(OP_I, 0, 1, 0, 3));  prog.push_back(enc_s(0, 1, 0));
    prog.push_back(enc_i(OP_I, 0, 1, 0, 1));  prog.push_back(enc_s(0, 1, 4));
    prog.push_back(enc_i(OP_I, 0, 1, 0, 4));  prog.push_back(enc_s(0, 1, 8));
    prog.push_back(enc_i(OP_I, 0, 1, 0, 2));  prog.push_back(enc_s(0, 1, 12));
    prog.push_back(enc_i(OP_I, 0, 10, 0, 3));       // 32 passes = 3
    prog.push_back(enc_i(OP_I, 0, 11, 0, 0));       // 36 ptr = 0
    prog.push_back(enc_i(OP_I, 0, 12, 0, 3));       // 40 compares = 3
    prog.push_back(enc_i(OP_LOAD, 2, 13, 11, 0));   // 44 lw x13,0(x11)
    prog.push_back(enc_i(OP_LOAD, 2, 14, 11, 4));   // 48 lw x14,4(x11)
    prog.push_back(enc_b(5, 14, 13, 12));           // 52 bge x14,x13,+12
    prog.push_back(enc_s(11, 14, 0));               // 56 sw x14,0(x11)
    prog.push_back(enc_s(11, 13, 4));               // 60 sw x13,4(x11)
    prog.push_back(enc_i(OP_I, 0, 11, 11, 4));      // 64 ptr += 4
    prog.push_back(enc_i(OP_I, 0, 12, 12, -1));     // 68 compares--
    prog.push_back(enc_b(1, 12, 0, -28));           // 72 bne -> 44
    prog.push_back(enc_i(OP_I, 0, 10, 10, -1));     // 76 passes--
    prog.push_back(enc_b(1, 10, 0, -44));           // 80 bne -> 36
    prog.push_back(enc_i(OP_LOAD, 2, 20, 0, 0));
    prog.push_back(enc_i(OP_LOAD, 2, 21, 0, 4));
    prog.push_back(enc_i(OP_LOAD, 2, 22, 0, 8));
    prog.push_back(enc_i(OP_LOAD, 2, 23, 0, 12));
    prog.push_back(enc_j(0, 0));                    // 100 halt
    start_prog(prog);
    repeat (160) cycle(1'b0);
    chk_reg("sort_w0", 20, 32'd1);
    chk_reg("sort_w1", 21, 32'd2);
    chk_reg("sort_w2", 22, 32'd3);
    chk_reg("sort_w3", 23, 32'd4);
    check("sort_pc_halt", dut.PC, 32'd100);
    repeat (3) cycle(1'b0);
    check("sort_pc_stays", dut.PC, 32'd100);

    // Random instruction streams, with one asynchronous reset mid-run
    for (int p = 0; p < 6; p++) begin
      prog = {};
      for (int i = 0; i < 128; i++) prog.push_back(rand_ins());
      start_prog(prog);
      for (int c = 0; c < 150; c++) begin
        if (p == 2 && c == 70) mid_reset();
        cycle(1'b1);
      end
    end

    reg_sel = 5'd0;
    #0.05;
    rs = reg_data;
    check("x0_final", rs, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
